// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_WAIT_TX,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO holding bytes received from the SPI engine.
// Latency: a push is visible at the head on the next cycle; the head is combinational from storage.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle; pop when empty is ignored.
// Ports: clk/rst, push + push_dat, pop, pop_dat (head, 0 when empty), full, empty, count (occupancy).
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Splits a multi-byte command into single-byte SPI engine starts and collects RX bytes into a FIFO.
// Latency: tx byte taken 1 cycle after tx_valid seen in S_WAIT_TX, eng_start the cycle after; RX push when eng_en returns high.
// Backpressure: no byte is started unless the RX FIFO has a free slot; RX read through rx_valid/rx_ready.
// Ports: cmd_valid/cmd_ready/cmd_len command; tx_data/tx_valid/tx_ready byte stream; rx_data/rx_valid/rx_ready
//   received bytes; busy, xfer_done, xfer_err status; eng_data_in/eng_start/eng_en/eng_data_out engine side.
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int RX_DEPTH = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  xfer_err,
    output logic [SPI_BYTE_W-1:0] eng_data_in,
    output logic                  eng_start,
    input  logic                  eng_en,
    input  logic [SPI_BYTE_W-1:0] eng_data_out
);

    localparam int CNT_W = $clog2(RX_DEPTH) + 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RX_CAP  = CNT_W'(RX_DEPTH);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [WD_W-1:0]  wd_cnt;
    logic             in_wait;
    logic             wd_expire;
    logic             cmd_take;

    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic             rx_has_slot;

    assign cmd_ready = (state == S_IDLE);
    assign tx_ready  = (state == S_START);
    assign busy      = (state != S_IDLE);
    assign cmd_take  = (state == S_IDLE) && cmd_valid;

    assign in_wait   = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
    assign wd_expire = in_wait && (wd_cnt == WD_LAST);

    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_ready && !rx_empty;
    // Only one byte is ever in flight, so a slot reserved here cannot be taken before the push.
    assign rx_has_slot = (rx_count != RX_CAP) || rx_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_push   = 1'b0;
        case (state)
            S_SYNC:      if (eng_en) state_nxt = S_IDLE;
            S_IDLE:      if (cmd_valid) state_nxt = (cmd_len == '0) ? S_DONE : S_WAIT_TX;
            S_WAIT_TX:   if (tx_valid && rx_has_slot) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (wd_expire)    state_nxt = S_SYNC;
                else if (!eng_en) state_nxt = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (wd_expire) begin
                    state_nxt = S_SYNC;
                end else if (eng_en) begin
                    rx_push   = 1'b1;
                    state_nxt = (remaining <= LEN_W'(1)) ? S_DONE : S_WAIT_TX;
                end
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining   <= '0;
            wd_cnt      <= '0;
            eng_start   <= 1'b0;
            eng_data_in <= '0;
            xfer_done   <= 1'b0;
            xfer_err    <= 1'b0;
        end else begin
            eng_start <= (state == S_START);
            xfer_done <= (state == S_DONE) || wd_expire;
            xfer_err  <= wd_expire;

            if (state == S_START) eng_data_in <= tx_data;

            // Decrement guarded at zero so a stray push can never wrap the count.
            if (cmd_take)
                remaining <= cmd_len;
            else if (rx_push && (remaining != '0))
                remaining <= remaining - 1'b1;

            // Counter runs only while waiting on the engine; any other state clears it.
            if (in_wait) wd_cnt <= wd_cnt + 1'b1;
            else         wd_cnt <= '0;
        end
    end

    spi_sync_fifo #(
        .WIDTH (SPI_BYTE_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (eng_data_out),
        .pop      (rx_pop),
        .pop_dat  (rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(rx_push && rx_full && !rx_pop));

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer with a behavioural SPI byte engine (loopback or fixed slave byte).
// Latency: engine byte time randomised per byte, always well inside the watchdog window.
// Backpressure: rx_ready driven randomly or held low to exercise the RX FIFO stall.
module tb_spi_xfer_sequencer;

    localparam int LEN_W    = 8;
    localparam int RX_DEPTH = 2;
    localparam int TIMEOUT  = 16;

    typedef logic [7:0] byte_t;
    typedef byte_t      byte_q_t [$];

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    byte_t            tx_data;
    logic             tx_valid;
    logic             tx_ready;
    byte_t            rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             xfer_done;
    logic             xfer_err;
    byte_t            eng_data_in;
    logic             eng_start;
    logic             eng_en;
    byte_t            eng_data_out;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .LEN_W    (LEN_W),
        .RX_DEPTH (RX_DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .xfer_done    (xfer_done),
        .xfer_err     (xfer_err),
        .eng_data_in  (eng_data_in),
        .eng_start    (eng_start),
        .eng_en       (eng_en),
        .eng_data_out (eng_data_out)
    );

    // ---------------- behavioural engine ----------------
    logic    stall      = 1'b0;
    logic    slave_mode = 1'b0;
    byte_t   slave_byte = 8'h00;
    byte_t   eng_cap;
    int      eng_cnt;
    logic    eng_first;
    byte_q_t eng_seen;
    int      bad_start  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_en       <= 1'b0;
            eng_first    <= 1'b1;
            eng_cnt      <= 0;
            eng_data_out <= 8'h00;
        end else begin
            if (eng_start && !eng_en) bad_start <= bad_start + 1;
            if (eng_first) begin
                eng_first <= 1'b0;
                eng_en    <= 1'b1;
            end else if (eng_cnt != 0) begin
                if (!stall) begin
                    eng_cnt <= eng_cnt - 1;
                    if (eng_cnt == 1) begin
                        eng_en       <= 1'b1;
                        eng_data_out <= slave_mode ? slave_byte : eng_cap;
                    end
                end
            end else if (eng_start) begin
                eng_seen.push_back(eng_data_in);
                eng_cap <= eng_data_in;
                eng_en  <= 1'b0;
                eng_cnt <= $urandom_range(2, 9);
            end
        end
    end

    // ---------------- bookkeeping and reference model ----------------
    int      n_chk = 0;
    int      n_pass = 0;
    int      cycle = 0;
    int      n_start, n_txr, n_done, n_err;
    int      start_cyc, done_cyc, err_cyc, hs_cyc;
    int      seen_base;
    int      snap_start, snap_txr, snap_done;
    logic    snap_rxv;
    byte_q_t src_q;
    byte_q_t exp_q;
    byte_q_t tx_sent;
    byte_q_t rx_got;

    task automatic clear_model();
        tx_sent.delete();
        rx_got.delete();
        exp_q.delete();
        n_start = 0; n_txr = 0; n_done = 0; n_err = 0;
        start_cyc = -1; done_cyc = -1; err_cyc = -1; hs_cyc = -1;
        seen_base = eng_seen.size();
    endtask

    // Every byte sent comes back either as itself (loopback) or as the slave's fixed byte.
    task automatic build_exp();
        exp_q.delete();
        foreach (src_q[i]) exp_q.push_back(slave_mode ? slave_byte : src_q[i]);
    endtask

    task automatic fill_src(input int len);
        src_q.delete();
        for (int i = 0; i < len; i++) src_q.push_back(byte_t'($urandom_range(0, 255)));
    endtask

    function automatic bit q_same(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit seen_ok();
        if (eng_seen.size() != seen_base + src_q.size()) return 1'b0;
        foreach (src_q[i]) if (eng_seen[seen_base + i] !== src_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Samples at the falling edge (inputs settled, outputs stable), then advances one cycle.
    task automatic cyc();
        if (tx_valid && tx_ready) tx_sent.push_back(tx_data);
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        if (eng_start) begin n_start++; start_cyc = cycle; end
        if (tx_ready)  n_txr++;
        if (xfer_done) begin n_done++; done_cyc = cycle; end
        if (xfer_err)  begin n_err++;  err_cyc  = cycle; end
        cycle++;
        @(negedge clk);
    endtask

    // Issues one command and feeds src_q; rx_ready held low for 'hold' cycles, then random at rdy_pct.
    task automatic do_xfer(input int len, input int rdy_pct, input int hold, input int abort_at);
        int idx = 0;
        bit got_cmd = 1'b0;
        int done0 = n_done;
        int ntx;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        tx_valid  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (n_done != done0) break;
            if (abort_at > 0 && n_start >= abort_at && !eng_en) break;
            if (hold > 0 && k == hold) begin
                snap_start = n_start; snap_txr = n_txr; snap_done = n_done; snap_rxv = rx_valid;
            end
            rx_ready = (k >= hold) && ($urandom_range(1, 100) <= rdy_pct);
            if (!tx_valid && idx < len && $urandom_range(0, 3) != 0) begin
                tx_valid = 1'b1;
                tx_data  = src_q[idx];
            end
            cmd_valid = !got_cmd;
            if (cmd_valid && cmd_ready) begin got_cmd = 1'b1; hs_cyc = cycle; end
            ntx = tx_sent.size();
            cyc();
            if (tx_sent.size() != ntx) begin idx++; tx_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        if (abort_at == 0) begin
            for (int k = 0; k < 50; k++) begin
                if (!rx_valid) break;
                rx_ready = 1'b1;
                cyc();
            end
            rx_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit found = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({cmd_ready, tx_ready, eng_start, xfer_done, xfer_err, rx_valid, busy} !== 7'b0000001)
            $display("FAIL reset_ctrl: got %b expected 0000001",
                     {cmd_ready, tx_ready, eng_start, xfer_done, xfer_err, rx_valid, busy});
        else n_pass++;
        n_chk++;
        if ({eng_data_in, rx_data} !== 16'h0000)
            $display("FAIL reset_data: got %h expected 0000", {eng_data_in, rx_data});
        else n_pass++;
        rst = 1'b0;
        cyc();
        n_chk++;
        if (cmd_ready !== 1'b0) $display("FAIL sync_hold: cmd_ready %b expected 0 while engine EN low", cmd_ready);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (cmd_ready === 1'b1) begin found = 1'b1; break; end
            cyc();
        end
        n_chk++;
        if (!(found && busy === 1'b0)) $display("FAIL sync_idle: found %0d busy %b expected 1/0", found, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        clear_model();
        slave_mode = 1'b0;
        src_q = '{8'hA5};
        build_exp();
        do_xfer(1, 100, 0, 0);
        n_chk++;
        if (n_start != 1) $display("FAIL single_starts: got %0d expected 1", n_start); else n_pass++;
        n_chk++;
        if (!q_same(rx_got, exp_q)) $display("FAIL single_rx: got %p expected %p", rx_got, exp_q); else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0) $display("FAIL single_done: done %0d err %0d expected 1/0", n_done, n_err);
        else n_pass++;
        n_chk++;
        if (!seen_ok()) $display("FAIL single_eng_data: engine saw %p expected %p", eng_seen, src_q); else n_pass++;
    endtask

    task automatic test_multi();
        clear_model();
        slave_mode = 1'b1;
        slave_byte = 8'h3C;
        src_q = '{8'h01, 8'h80, 8'hFF};
        build_exp();
        do_xfer(3, 60, 0, 0);
        n_chk++;
        if (!q_same(rx_got, exp_q)) $display("FAIL multi_rx: got %p expected %p", rx_got, exp_q); else n_pass++;
        n_chk++;
        if (n_start != 3 || !seen_ok()) $display("FAIL multi_starts: got %0d starts expected 3 in order", n_start);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0 || done_cyc <= start_cyc)
            $display("FAIL multi_done: done %0d err %0d done@%0d last start@%0d", n_done, n_err, done_cyc, start_cyc);
        else n_pass++;
        slave_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_model();
        slave_mode = 1'b0;
        fill_src(4);
        build_exp();
        do_xfer(4, 100, 80, 0);
        n_chk++;
        if (snap_start != RX_DEPTH || snap_txr != RX_DEPTH)
            $display("FAIL bp_stall: starts %0d tx_ready %0d expected %0d each", snap_start, snap_txr, RX_DEPTH);
        else n_pass++;
        n_chk++;
        if (snap_done != 0 || snap_rxv !== 1'b1)
            $display("FAIL bp_state: done %0d rx_valid %b expected 0/1", snap_done, snap_rxv);
        else n_pass++;
        n_chk++;
        if (!q_same(rx_got, exp_q)) $display("FAIL bp_order: got %p expected %p", rx_got, exp_q); else n_pass++;
        n_chk++;
        if (n_start != 4 || n_done != 1) $display("FAIL bp_finish: starts %0d done %0d expected 4/1", n_start, n_done);
        else n_pass++;
    endtask

    task automatic test_empty();
        clear_model();
        src_q.delete();
        do_xfer(0, 100, 0, 0);
        n_chk++;
        if (done_cyc - hs_cyc != 2) $display("FAIL empty_latency: got %0d expected 2", done_cyc - hs_cyc); else n_pass++;
        n_chk++;
        if (n_start != 0 || n_txr != 0) $display("FAIL empty_quiet: starts %0d tx_ready %0d expected 0/0", n_start, n_txr);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || n_err != 0) $display("FAIL empty_done: done %0d err %0d expected 1/0", n_done, n_err);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int  ready_seen = 0;
        bit  found = 1'b0;
        clear_model();
        stall = 1'b1;
        fill_src(3);
        do_xfer(3, 100, 0, 0);
        n_chk++;
        if (n_err != 1 || err_cyc != done_cyc)
            $display("FAIL wd_pulse: err %0d err@%0d done@%0d expected 1 coincident", n_err, err_cyc, done_cyc);
        else n_pass++;
        n_chk++;
        if (err_cyc - start_cyc != TIMEOUT)
            $display("FAIL wd_latency: got %0d expected %0d", err_cyc - start_cyc, TIMEOUT);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) ready_seen++;
            cyc();
        end
        n_chk++;
        if (ready_seen != 0 || busy !== 1'b1)
            $display("FAIL wd_sync: cmd_ready seen %0d busy %b expected 0/1", ready_seen, busy);
        else n_pass++;
        n_chk++;
        if (n_txr != 1 || n_start != 1 || rx_got.size() != 0)
            $display("FAIL wd_abandon: tx_ready %0d starts %0d rx %0d expected 1/1/0", n_txr, n_start, rx_got.size());
        else n_pass++;
        stall = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cmd_ready === 1'b1) begin found = 1'b1; break; end
            cyc();
        end
        n_chk++;
        if (!found) $display("FAIL wd_recover: cmd_ready %b expected 1 after engine release", cmd_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_model();
        slave_mode = 1'b0;
        fill_src(3);
        do_xfer(3, 100, 0, 2);
        n_chk++;
        if (n_start != 2 || eng_en !== 1'b0)
            $display("FAIL mid_setup: starts %0d eng_en %b expected 2/0", n_start, eng_en);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({cmd_ready, tx_ready, eng_start, xfer_done, xfer_err, rx_valid, busy} !== 7'b0000001)
            $display("FAIL mid_reset_ctrl: got %b expected 0000001",
                     {cmd_ready, tx_ready, eng_start, xfer_done, xfer_err, rx_valid, busy});
        else n_pass++;
        n_chk++;
        if ({eng_data_in, rx_data} !== 16'h0000)
            $display("FAIL mid_reset_data: got %h expected 0000", {eng_data_in, rx_data});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        fill_src(1);
        build_exp();
        do_xfer(1, 100, 0, 0);
        n_chk++;
        if (!q_same(rx_got, exp_q) || n_start != 1 || n_done != 1 || n_err != 0)
            $display("FAIL mid_after: rx %p expected %p starts %0d done %0d", rx_got, exp_q, n_start, n_done);
        else n_pass++;
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 5; t++) begin
            clear_model();
            len        = $urandom_range(1, 6);
            slave_mode = logic'($urandom_range(0, 1));
            slave_byte = byte_t'($urandom_range(0, 255));
            fill_src(len);
            build_exp();
            do_xfer(len, $urandom_range(20, 100), 0, 0);
            n_chk++;
            if (!q_same(rx_got, exp_q)) $display("FAIL rand%0d_rx: got %p expected %p", t, rx_got, exp_q);
            else n_pass++;
            n_chk++;
            if (!q_same(tx_sent, src_q) || !seen_ok() || n_start != len)
                $display("FAIL rand%0d_tx: sent %p starts %0d expected %p", t, tx_sent, n_start, src_q);
            else n_pass++;
            n_chk++;
            if (n_done != 1 || n_err != 0) $display("FAIL rand%0d_done: done %0d err %0d expected 1/0", t, n_done, n_err);
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_empty();
        test_watchdog();
        test_reset_mid();
        test_random();
        n_chk++;
        if (bad_start != 0) $display("FAIL start_while_busy: got %0d expected 0", bad_start); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
